// File: rtl/dfd_trace_net_if.sv
// Trace network interface: drains packetizer FIFO entries into 64-byte lines
// and writes them to a line-aligned circular trace buffer over a valid/ready channel.
module dfd_trace_net_if #(
    parameter int unsigned FIFO_WIDTH_IN_BYTES = 16,
    parameter int unsigned BEATS_PER_LINE      = 4,
    parameter int unsigned ADDR_WIDTH          = 48,
    parameter int unsigned MAX_OUTSTANDING     = 4
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic                                            enable,
    input  logic [ADDR_WIDTH-1:0]                           cfg_base_addr,
    input  logic [ADDR_WIDTH-1:0]                           cfg_limit_addr,
    input  logic                                            cfg_wrap_enable,
    input  logic                                            tnif_req_in,
    input  logic [FIFO_WIDTH_IN_BYTES*8-1:0]                tnif_data_in,
    output logic                                            tnif_data_pull_out,
    input  logic                                            flush_req,
    output logic                                            flush_done,
    output logic                                            net_req_valid,
    input  logic                                            net_req_ready,
    output logic [ADDR_WIDTH-1:0]                           net_req_addr,
    output logic [FIFO_WIDTH_IN_BYTES*8*BEATS_PER_LINE-1:0] net_req_data,
    output logic [FIFO_WIDTH_IN_BYTES*BEATS_PER_LINE-1:0]   net_req_be,
    input  logic                                            net_resp_valid,
    output logic [ADDR_WIDTH-1:0]                           write_ptr,
    output logic [15:0]                                     wrap_count,
    output logic                                            buffer_full
);

    localparam int unsigned DW         = FIFO_WIDTH_IN_BYTES * 8;
    localparam int unsigned LINE_BYTES = FIFO_WIDTH_IN_BYTES * BEATS_PER_LINE;
    localparam int unsigned LINE_W     = DW * BEATS_PER_LINE;
    localparam int unsigned LB         = $clog2(LINE_BYTES);
    localparam int unsigned CW         = $clog2(BEATS_PER_LINE + 1);
    localparam int unsigned OW         = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [CW-1:0]         LAST_BEAT  = CW'(BEATS_PER_LINE - 1);
    localparam logic [OW-1:0]         MAX_OS     = OW'(MAX_OUTSTANDING);
    localparam logic [ADDR_WIDTH-1:0] LINE_STEP  = ADDR_WIDTH'(LINE_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        GATHER,
        SEND,
        STOPPED
    } state_e;

    state_e                    state_q;
    logic [ADDR_WIDTH-1:0]     write_ptr_q;
    logic [15:0]               wrap_count_q;
    logic                      buffer_full_q;
    logic [OW-1:0]             outstanding_q;
    logic [CW-1:0]             beat_cnt_q;
    logic [LINE_W-1:0]         line_q;
    logic [LINE_BYTES-1:0]     be_q;

    logic                      gather_exit;
    logic                      pull;
    logic                      accept;
    logic                      resp_take;
    logic                      at_limit;
    logic [ADDR_WIDTH-1:0]     base_line;

    always_comb begin
        base_line = cfg_base_addr;
        base_line[LB-1:0] = '0;
    end

    // An empty line with enable dropped leaves GATHER without popping, so no entry is lost.
    assign gather_exit = (state_q == GATHER) && !enable && (beat_cnt_q == '0);
    assign pull        = (state_q == GATHER) && tnif_req_in && !flush_req && !gather_exit;
    assign net_req_valid = (state_q == SEND) && (outstanding_q < MAX_OS);
    assign accept      = net_req_valid && net_req_ready;
    assign resp_take   = net_resp_valid && (outstanding_q != '0);
    assign at_limit    = (write_ptr_q[ADDR_WIDTH-1:LB] == cfg_limit_addr[ADDR_WIDTH-1:LB]);

    assign tnif_data_pull_out = pull;
    assign net_req_addr       = write_ptr_q;
    assign net_req_data       = line_q;
    assign net_req_be         = be_q;
    assign write_ptr          = write_ptr_q;
    assign wrap_count         = wrap_count_q;
    assign buffer_full        = buffer_full_q;
    assign flush_done         = flush_req && (state_q != SEND) && (beat_cnt_q == '0)
                                && (outstanding_q == '0) && !tnif_req_in;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            write_ptr_q   <= '0;
            wrap_count_q  <= '0;
            buffer_full_q <= 1'b0;
            outstanding_q <= '0;
            beat_cnt_q    <= '0;
            line_q        <= '0;
            be_q          <= '0;
        end else begin
            case ({accept, resp_take})
                2'b10:   outstanding_q <= outstanding_q + OW'(1);
                2'b01:   outstanding_q <= outstanding_q - OW'(1);
                default: outstanding_q <= outstanding_q;
            endcase

            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q       <= GATHER;
                        write_ptr_q   <= base_line;
                        beat_cnt_q    <= '0;
                        buffer_full_q <= 1'b0;
                    end
                end
                GATHER: begin
                    if (pull) begin
                        for (int unsigned i = 0; i < BEATS_PER_LINE; i++) begin
                            if (beat_cnt_q == CW'(i)) begin
                                line_q[i*DW +: DW]                                   <= tnif_data_in;
                                be_q[i*FIFO_WIDTH_IN_BYTES +: FIFO_WIDTH_IN_BYTES]   <= '1;
                            end
                        end
                        beat_cnt_q <= beat_cnt_q + CW'(1);
                        if (beat_cnt_q == LAST_BEAT) begin
                            state_q <= SEND;
                        end
                    end else if (flush_req && (beat_cnt_q != '0)) begin
                        state_q <= SEND;
                    end else if (gather_exit) begin
                        state_q <= IDLE;
                    end
                end
                SEND: begin
                    if (accept) begin
                        beat_cnt_q <= '0;
                        line_q     <= '0;
                        be_q       <= '0;
                        if (at_limit) begin
                            if (cfg_wrap_enable) begin
                                write_ptr_q <= base_line;
                                if (wrap_count_q != '1) begin
                                    wrap_count_q <= wrap_count_q + 16'd1;
                                end
                                state_q <= GATHER;
                            end else begin
                                buffer_full_q <= 1'b1;
                                state_q       <= STOPPED;
                            end
                        end else begin
                            write_ptr_q <= write_ptr_q + LINE_STEP;
                            state_q     <= GATHER;
                        end
                    end
                end
                STOPPED: begin
                    if (!enable) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dfd_trace_net_if.sv
// Directed self-checking bench for dfd_trace_net_if: wrap, stop-on-full, flush,
// credit limit, request stall and reset behaviour.
module tb_dfd_trace_net_if;

    localparam int AW = 48;

    logic          clock = 1'b0;
    logic          reset, enable, cfg_wrap_enable;
    logic [AW-1:0] cfg_base_addr, cfg_limit_addr;
    logic          tnif_req_in, tnif_data_pull_out;
    logic [127:0]  tnif_data_in;
    logic          flush_req, flush_done;
    logic          net_req_valid, net_req_ready, net_resp_valid;
    logic [AW-1:0] net_req_addr, write_ptr;
    logic [511:0]  net_req_data;
    logic [63:0]   net_req_be;
    logic [15:0]   wrap_count;
    logic          buffer_full;

    dfd_trace_net_if #(
        .FIFO_WIDTH_IN_BYTES(16),
        .BEATS_PER_LINE     (4),
        .ADDR_WIDTH         (AW),
        .MAX_OUTSTANDING    (4)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .enable            (enable),
        .cfg_base_addr     (cfg_base_addr),
        .cfg_limit_addr    (cfg_limit_addr),
        .cfg_wrap_enable   (cfg_wrap_enable),
        .tnif_req_in       (tnif_req_in),
        .tnif_data_in      (tnif_data_in),
        .tnif_data_pull_out(tnif_data_pull_out),
        .flush_req         (flush_req),
        .flush_done        (flush_done),
        .net_req_valid     (net_req_valid),
        .net_req_ready     (net_req_ready),
        .net_req_addr      (net_req_addr),
        .net_req_data      (net_req_data),
        .net_req_be        (net_req_be),
        .net_resp_valid    (net_resp_valid),
        .write_ptr         (write_ptr),
        .wrap_count        (wrap_count),
        .buffer_full       (buffer_full)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    logic [127:0] up_q[$];
    logic [AW-1:0] acc_addr[$];
    logic [511:0]  acc_data[$];
    logic [63:0]   acc_be[$];
    int            acc_cyc[$];
    bit            auto_ack;
    bit            manual_resp;
    int            pend_ack;
    int            coinc_at;

    function automatic logic [127:0] ent(input int k);
        logic [31:0] kk;
        kk = 32'(k);
        return {32'hA5A5_0000 + kk, 32'h1111_0000 + kk, 32'h2222_0000 + kk, 32'h3333_0000 + kk};
    endfunction

    function automatic logic [511:0] line_of(input int start, input int nbeats);
        logic [511:0] l;
        l = '0;
        for (int b = 0; b < nbeats; b++) l[b*128 +: 128] = ent(start + b);
        return l;
    endfunction

    task automatic push_entries(input int first, input int n);
        for (int i = 0; i < n; i++) up_q.push_back(ent(first + i));
    endtask

    // One cycle: drive at negedge, observe combinational outputs 1 ns later.
    task automatic step();
        logic [127:0] tmp;
        tnif_req_in  = (up_q.size() != 0);
        tnif_data_in = '0;
        if (tnif_req_in) tnif_data_in = up_q[0];
        net_resp_valid = manual_resp;
        if (auto_ack && pend_ack > 0) begin
            net_resp_valid = 1'b1;
            pend_ack--;
        end
        #1;
        if (tnif_data_pull_out) tmp = up_q.pop_front();
        if (net_req_valid && net_req_ready) begin
            if (coinc_at == acc_addr.size()) net_resp_valid = 1'b1;
            acc_addr.push_back(net_req_addr);
            acc_data.push_back(net_req_data);
            acc_be.push_back(net_req_be);
            acc_cyc.push_back(cyc);
            if (auto_ack) pend_ack++;
        end
        @(negedge clock);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; flush_req = 1'b0; net_req_ready = 1'b0;
        net_resp_valid = 1'b0; tnif_req_in = 1'b0; tnif_data_in = '0;
        cfg_base_addr = 48'h1000; cfg_limit_addr = 48'h10C0; cfg_wrap_enable = 1'b1;
        auto_ack = 1'b0; manual_resp = 1'b0; pend_ack = 0; coinc_at = -1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        up_q.delete(); acc_addr.delete(); acc_data.delete(); acc_be.delete(); acc_cyc.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({net_req_valid, tnif_data_pull_out, buffer_full, flush_done} !== 4'b0000) begin
            $display("FAIL reset_ctrl got v/p/full/fd=%b req 0000", {net_req_valid, tnif_data_pull_out, buffer_full, flush_done});
        end else n_pass++;
        n_total++;
        if (write_ptr !== 48'h0 || wrap_count !== 16'h0 || net_req_addr !== 48'h0) begin
            $display("FAIL reset_ptr got ptr=%h wraps=%h addr=%h req 0/0/0", write_ptr, wrap_count, net_req_addr);
        end else n_pass++;
        n_total++;
        if (net_req_data !== 512'h0 || net_req_be !== 64'h0) begin
            $display("FAIL reset_line got be=%h req 0", net_req_be);
        end else n_pass++;
        flush_req = 1'b1;
        #1;
        n_total++;
        if (flush_done !== 1'b1) $display("FAIL reset_flush_done got %b req 1", flush_done);
        else n_pass++;
        flush_req = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_wrap();
        do_reset();
        auto_ack = 1'b1; net_req_ready = 1'b1;
        push_entries(0, 16);
        enable = 1'b1;
        run(40);
        n_total++;
        if (acc_addr.size() !== 4) $display("FAIL wrap_count_writes got %0d req 4", acc_addr.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < acc_addr.size(); i++) begin
            n_total++;
            if (acc_addr[i] !== 48'h1000 + 48'(64 * i) || acc_data[i] !== line_of(4 * i, 4) || acc_be[i] !== '1) begin
                $display("FAIL wrap_line%0d got addr=%h be=%h req addr=%h be=all-ones", i, acc_addr[i], acc_be[i], 48'h1000 + 48'(64 * i));
            end else n_pass++;
        end
        n_total++;
        if (acc_cyc.size() < 2 || acc_cyc[1] - acc_cyc[0] !== 5) $display("FAIL wrap_throughput got spacing %0d req 5", acc_cyc.size() < 2 ? -1 : acc_cyc[1] - acc_cyc[0]);
        else n_pass++;
        n_total++;
        if (write_ptr !== 48'h1000 || wrap_count !== 16'd1) $display("FAIL wrap_ptr got ptr=%h wraps=%0d req 1000/1", write_ptr, wrap_count);
        else n_pass++;
    endtask

    task automatic test_stop_full();
        do_reset();
        auto_ack = 1'b1; net_req_ready = 1'b1; cfg_wrap_enable = 1'b0;
        push_entries(0, 20);
        enable = 1'b1;
        run(40);
        n_total++;
        if (acc_addr.size() !== 4 || buffer_full !== 1'b1) $display("FAIL stop_full got writes=%0d full=%b req 4/1", acc_addr.size(), buffer_full);
        else n_pass++;
        tnif_req_in = (up_q.size() != 0);
        #1;
        n_total++;
        if (tnif_data_pull_out !== 1'b0 || up_q.size() !== 4 || tnif_req_in !== 1'b1) begin
            $display("FAIL stop_backpressure got pull=%b left=%0d req pull=0 left=4", tnif_data_pull_out, up_q.size());
        end else n_pass++;
        @(negedge clock);
        enable = 1'b0;
        run(2);
        enable = 1'b1;
        run(15);
        n_total++;
        if (acc_addr.size() !== 5 || acc_addr[acc_addr.size()-1] !== 48'h1000 || acc_data[acc_data.size()-1] !== line_of(16, 4)) begin
            $display("FAIL stop_restart got writes=%0d last_addr=%h req 5/1000", acc_addr.size(), acc_addr[acc_addr.size()-1]);
        end else n_pass++;
        n_total++;
        if (buffer_full !== 1'b0) $display("FAIL stop_full_clear got %b req 0", buffer_full);
        else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        auto_ack = 1'b1; net_req_ready = 1'b1; cfg_limit_addr = 48'h1FC0;
        push_entries(0, 6);
        enable = 1'b1;
        run(12);
        flush_req = 1'b1;
        tnif_req_in = 1'b0;
        net_resp_valid = 1'b0;
        #1;
        n_total++;
        if (flush_done !== 1'b0 || tnif_data_pull_out !== 1'b0) $display("FAIL flush_partial_pending got fd=%b pull=%b req 0/0", flush_done, tnif_data_pull_out);
        else n_pass++;
        @(negedge clock);
        run(10);
        n_total++;
        if (acc_addr.size() !== 2) $display("FAIL flush_writes got %0d req 2", acc_addr.size());
        else n_pass++;
        n_total++;
        if (acc_addr.size() < 2 || acc_addr[1] !== 48'h1040 || acc_be[1] !== 64'h0000_0000_FFFF_FFFF || acc_data[1] !== line_of(4, 2)) begin
            $display("FAIL flush_line got addr=%h be=%h req 1040/00000000ffffffff", acc_addr[acc_addr.size()-1], acc_be[acc_be.size()-1]);
        end else n_pass++;
        n_total++;
        if (flush_done !== 1'b1) $display("FAIL flush_done got %b req 1", flush_done);
        else n_pass++;
        flush_req = 1'b0;
        #1;
        n_total++;
        if (flush_done !== 1'b0) $display("FAIL flush_done_drop got %b req 0", flush_done);
        else n_pass++;
        @(negedge clock);
    endtask

    task automatic test_credit_limit();
        do_reset();
        net_req_ready = 1'b1; cfg_limit_addr = 48'h1FC0;
        push_entries(0, 24);
        enable = 1'b1;
        run(40);
        n_total++;
        if (acc_addr.size() !== 4 || net_req_valid !== 1'b0) $display("FAIL credit_cap got writes=%0d valid=%b req 4/0", acc_addr.size(), net_req_valid);
        else n_pass++;
        manual_resp = 1'b1;
        step();
        manual_resp = 1'b0;
        run(15);
        n_total++;
        if (acc_addr.size() !== 5 || acc_addr[4] !== 48'h1100 || net_req_valid !== 1'b0) begin
            $display("FAIL credit_one_more got writes=%0d valid=%b req 5/0", acc_addr.size(), net_req_valid);
        end else n_pass++;
    endtask

    task automatic test_coincident();
        do_reset();
        net_req_ready = 1'b1; cfg_limit_addr = 48'h1FC0; coinc_at = 3;
        push_entries(0, 24);
        enable = 1'b1;
        run(45);
        n_total++;
        if (acc_addr.size() !== 5 || net_req_valid !== 1'b0) $display("FAIL coincident_resp got writes=%0d valid=%b req 5/0", acc_addr.size(), net_req_valid);
        else n_pass++;
    endtask

    task automatic test_ready_stall();
        do_reset();
        auto_ack = 1'b1; net_req_ready = 1'b0; cfg_limit_addr = 48'h1FC0;
        push_entries(0, 12);
        enable = 1'b1;
        run(5);
        for (int i = 0; i < 10; i++) begin
            tnif_req_in  = (up_q.size() != 0);
            tnif_data_in = up_q[0];
            #1;
            n_total++;
            if (net_req_valid !== 1'b1 || tnif_data_pull_out !== 1'b0 || net_req_addr !== 48'h1000
                || net_req_be !== 64'hFFFF_FFFF_FFFF_FFFF || net_req_data !== line_of(0, 4)) begin
                $display("FAIL stall_hold%0d got valid=%b pull=%b addr=%h be=%h req 1/0/1000/all-ones", i, net_req_valid, tnif_data_pull_out, net_req_addr, net_req_be);
            end else n_pass++;
            @(negedge clock);
        end
        net_req_ready = 1'b1;
        step();
        net_req_ready = 1'b0;
        n_total++;
        if (acc_addr.size() !== 1 || acc_addr[0] !== 48'h1000) $display("FAIL stall_release got writes=%0d req 1", acc_addr.size());
        else n_pass++;
        run(6);
        n_total++;
        if (net_req_valid !== 1'b1 || net_req_addr !== 48'h1040) $display("FAIL stall_second_send got valid=%b addr=%h req 1/1040", net_req_valid, net_req_addr);
        else n_pass++;
        reset = 1'b1;
        @(negedge clock);
        n_total++;
        if (net_req_valid !== 1'b0 || write_ptr !== 48'h0) $display("FAIL reset_mid_send got valid=%b ptr=%h req 0/0", net_req_valid, write_ptr);
        else n_pass++;
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_wrap();
        test_stop_full();
        test_flush();
        test_credit_limit();
        test_coincident();
        test_ready_stall();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
